// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, port indices
// and the round-robin pick.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // On a tie the port that was not granted last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return (last == PORT1) ? PORT0 : PORT1;
    return r1 ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/register_8bit.sv
// Enable-loaded register with asynchronous clear; used for the arbiter's
// address and write-data latches.
module register_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)        q <= '0;
    else if (enable) q <= d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving two requesters access to one synchronous
// single-port memory; one access per IDLE/ACCESS/WAIT/DONE pass.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              grant, win;
  logic              we_q, idx_q, last_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign grant   = (state_q == IDLE) && (req0 || req1);
  assign win     = rr_pick(req0, req1, last_q);
  assign addr_d  = (win == PORT1) ? addr1  : addr0;
  assign wdata_d = (win == PORT1) ? wdata1 : wdata0;

  // The latches drive the memory bus directly, so it holds its last value
  // between accesses.
  register_8bit #(.WIDTH(ADDR_W)) u_addr_reg (
    .clock  (clock),
    .aclr   (reset),
    .enable (grant),
    .d      (addr_d),
    .q      (mem_addr)
  );

  register_8bit #(.WIDTH(DATA_W)) u_wdata_reg (
    .clock  (clock),
    .aclr   (reset),
    .enable (grant),
    .d      (wdata_d),
    .q      (mem_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      idx_q   <= PORT0;
      last_q  <= PORT1;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        we_q  <= (win == PORT1) ? we1 : we0;
        idx_q <= win;
      end
      // mem_q is valid during WAIT, one clock after ACCESS presented the address.
      if (state_q == WAIT && !we_q) begin
        if (idx_q == PORT1) rdata1 <= mem_q;
        else                rdata0 <= mem_q;
      end
      if (state_q == DONE) last_q <= idx_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enables decode from the state register alone, so reset drops them at once.
  always_comb begin
    mem_wren = 1'b0;
    mem_rden = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    busy     = (state_q != IDLE);
    if (state_q == ACCESS) begin
      mem_wren = we_q;
      mem_rden = !we_q;
    end
    if (state_q == DONE) begin
      ack0 = (idx_q == PORT0);
      ack1 = (idx_q == PORT1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions plus hand-written
// contention, mid-transaction-change and reset-abort sequences.
module tb_mem_port_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic       ack0, ack1, mem_wren, mem_rden, busy;
  logic [7:0] rdata0, rdata1, mem_addr, mem_data;
  logic [7:0] mem_q = 0;
  logic [7:0] mem [256];

  int n_chk = 0, n_fail = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_q(mem_q), .busy(busy)
  );

  always #5 clock = ~clock;

  // Synchronous single-port memory model.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr] <= mem_data;
    if (mem_rden) mem_q <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rd_m [2];
  int         en_cnt = 0;

  // Scoreboard monitor: checks the memory access and the ack of each transaction.
  always @(negedge clock) begin
    if (reset) begin
      en_cnt   = 0;
      rd_m[0]  = 8'h00;
      rd_m[1]  = 8'h00;
    end else begin
      if (mem_wren || mem_rden) begin
        en_cnt++;
        if (sb.size() > 0) begin
          chk("mem_addr", mem_addr, sb[0].addr);
          chk("mem_wren", mem_wren, sb[0].we);
          chk("mem_rden", mem_rden, !sb[0].we);
          if (sb[0].we) chk("mem_data", mem_data, sb[0].wdata);
        end
      end
      if (ack0 || ack1) begin
        exp_t e;
        chk("ack_exclusive", ack0 && ack1, 0);
        chk("enable_cycles", en_cnt, 1);
        en_cnt = 0;
        if (sb.size() == 0) chk("unexpected_ack", 1, sb.size());
        else begin
          e = sb.pop_front();
          chk("ack_port", ack1, e.port);
          if (!e.we) rd_m[e.port] = e.rdata;
          chk("rdata0", rdata0, rd_m[0]);
          chk("rdata1", rdata1, rd_m[1]);
        end
      end
    end
  end

  task automatic do_txn(input logic p, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] er);
    int lat;
    @(negedge clock);
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    sb.push_back('{port: p, we: w, addr: a, wdata: d, rdata: er});
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (p ? ack1 : ack0) begin lat = i + 1; break; end
    end
    chk("ack_cycle", lat, 4);
    req0 = 0; req1 = 0;
  endtask

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  vec_t vt [11];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1, 1, 8'h10, 8'hA5, 8'h00};
    vt[1]  = '{0, 0, 8'h10, 8'h00, 8'hA5};
    vt[2]  = '{1, 1, 8'h20, 8'h3C, 8'h00};
    vt[3]  = '{0, 0, 8'h20, 8'h00, 8'h3C};
    vt[4]  = '{1, 0, 8'h20, 8'h00, 8'h3C};
    vt[5]  = '{0, 1, 8'hFF, 8'h5A, 8'h00};
    vt[6]  = '{0, 0, 8'hFF, 8'h00, 8'h5A};
    vt[7]  = '{1, 1, 8'h00, 8'h11, 8'h00};
    vt[8]  = '{1, 0, 8'h00, 8'h00, 8'h11};
    vt[9]  = '{0, 1, 8'h10, 8'h77, 8'h00};
    vt[10] = '{1, 0, 8'h10, 8'h00, 8'h77};

    // Reset state
    @(negedge clock); @(negedge clock);
    chk("rst_ack0", ack0, 0);       chk("rst_ack1", ack1, 0);
    chk("rst_wren", mem_wren, 0);   chk("rst_rden", mem_rden, 0);
    chk("rst_addr", mem_addr, 0);   chk("rst_data", mem_data, 0);
    chk("rst_rdata0", rdata0, 0);   chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 0);
    reset = 0;

    for (int i = 0; i < 11; i++)
      do_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata);

    // Contention right after reset: port 0 wins first, then strict alternation.
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    req0 = 1; we0 = 0; addr0 = 8'h10;
    req1 = 1; we1 = 0; addr1 = 8'h20;
    for (int k = 0; k < 4; k++)
      sb.push_back('{port: k[0], we: 0, addr: k[0] ? 8'h20 : 8'h10, wdata: 0,
                     rdata: k[0] ? 8'h3C : 8'h77});
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = 0;
      for (int i = 1; i <= 12; i++) begin
        @(negedge clock);
        if (ack0 || ack1) begin gap = i; break; end
      end
      chk(k == 0 ? "contend_first_ack" : "contend_ack_spacing", gap, k == 0 ? 3 : 4);
    end
    req0 = 0; req1 = 0;

    // Inputs change and req drops right after the grant.
    @(negedge clock);
    req0 = 1; we0 = 0; addr0 = 8'h20;
    sb.push_back('{port: 0, we: 0, addr: 8'h20, wdata: 0, rdata: 8'h3C});
    @(negedge clock);
    chk("midchange_busy", busy, 1);
    addr0 = 8'hFF; req0 = 0;
    begin
      int lat;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clock);
        if (ack0) begin lat = i; break; end
      end
      chk("midchange_ack", lat, 2);
    end

    // Reset while a write is in ACCESS: enable falls asynchronously, no ack.
    @(negedge clock);
    req1 = 1; we1 = 1; addr1 = 8'h00; wdata1 = 8'hEE;
    @(posedge clock); #2;
    chk("abort_wren_before", mem_wren, 1);
    reset = 1; #1;
    chk("abort_wren_async", mem_wren, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack1", ack1, 0);
    req1 = 0;
    @(negedge clock); @(negedge clock);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("abort_no_ack", ack0 | ack1, 0);
    end
    do_txn(0, 0, 8'h00, 8'h00, 8'h11);
    do_txn(1, 0, 8'hFF, 8'h00, 8'h5A);

    @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
